// File: rtl/vend_stock_ctrl.sv
// Inventory controller in front of a 4x4-bit stock RAM: seeds the slots after
// reset, then serves vend (read-check-decrement-write) and restock (read-add-saturate-write).
`timescale 1ns/1ps
module vend_stock_ctrl #(
  parameter logic [3:0] INIT_STOCK = 4'd5,
  parameter logic [3:0] MAX_STOCK  = 4'd15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] sel,
  input  logic       vend_req,
  input  logic       restock_req,
  input  logic [3:0] restock_qty,
  output logic       mem_we,
  output logic       mem_re,
  output logic [1:0] mem_addr,
  output logic [3:0] mem_wdata,
  input  logic [3:0] mem_rdata,
  output logic       busy,
  output logic       vend_ok,
  output logic       sold_out,
  output logic       restock_done,
  output logic [3:0] stock_out
);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_READ, S_CHECK, S_WRITE
  } state_t;

  state_t     state_q;
  logic [1:0] cnt_q;
  logic [1:0] sel_q;
  logic       op_vend_q;
  logic [3:0] qty_q;
  logic [3:0] new_q;
  logic       vend_ok_q, sold_out_q, restock_done_q;
  logic [3:0] stock_q;

  // Sum is formed at 5 bits so an overflow clamps instead of wrapping.
  function automatic logic [3:0] sat_add(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, MAX_STOCK}) return MAX_STOCK;
    return s[3:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_INIT;
      cnt_q          <= 2'd0;
      sel_q          <= 2'd0;
      op_vend_q      <= 1'b0;
      qty_q          <= 4'd0;
      new_q          <= 4'd0;
      vend_ok_q      <= 1'b0;
      sold_out_q     <= 1'b0;
      restock_done_q <= 1'b0;
      stock_q        <= 4'd0;
    end else begin
      vend_ok_q      <= 1'b0;
      sold_out_q     <= 1'b0;
      restock_done_q <= 1'b0;
      case (state_q)
        S_INIT: begin
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (vend_req || restock_req) begin
            sel_q     <= sel;
            op_vend_q <= vend_req;
            qty_q     <= restock_qty;
            state_q   <= S_READ;
          end
        end
        S_READ: state_q <= S_CHECK;
        S_CHECK: begin
          if (op_vend_q) begin
            if (mem_rdata == 4'd0) begin
              sold_out_q <= 1'b1;
              stock_q    <= 4'd0;
              state_q    <= S_IDLE;
            end else begin
              new_q     <= mem_rdata - 4'd1;
              stock_q   <= mem_rdata - 4'd1;
              vend_ok_q <= 1'b1;
              state_q   <= S_WRITE;
            end
          end else begin
            new_q          <= sat_add(mem_rdata, qty_q);
            stock_q        <= sat_add(mem_rdata, qty_q);
            restock_done_q <= 1'b1;
            state_q        <= S_WRITE;
          end
        end
        S_WRITE: state_q <= S_IDLE;
        default: state_q <= S_INIT;
      endcase
    end
  end

  // RAM strobes are gated by rst_n so an abort never leaks a write.
  assign mem_we    = rst_n && ((state_q == S_INIT) || (state_q == S_WRITE));
  assign mem_re    = rst_n && (state_q == S_READ);
  assign mem_addr  = (state_q == S_INIT) ? cnt_q : sel_q;
  assign mem_wdata = (state_q == S_INIT) ? (rst_n ? INIT_STOCK : 4'd0) : new_q;
  assign busy      = (state_q != S_IDLE);

  assign vend_ok      = vend_ok_q;
  assign sold_out     = sold_out_q;
  assign restock_done = restock_done_q;
  assign stock_out    = stock_q;

endmodule

// File: tb/tb_vend_stock_ctrl.sv
// Directed bench for vend_stock_ctrl with a behavioural 4x4 stock RAM.
`timescale 1ns/1ps
module tb_vend_stock_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       vend_req = 1'b0;
  logic       restock_req = 1'b0;
  logic [3:0] restock_qty = 4'd0;
  logic       mem_we, mem_re;
  logic [1:0] mem_addr;
  logic [3:0] mem_wdata;
  logic [3:0] mem_rdata;
  logic       busy, vend_ok, sold_out, restock_done;
  logic [3:0] stock_out;

  logic [3:0] ram [4];
  int wcount = 0;
  int vcount = 0;
  int total = 0;
  int bad = 0;

  vend_stock_ctrl dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .vend_req(vend_req),
    .restock_req(restock_req), .restock_qty(restock_qty),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy),
    .vend_ok(vend_ok), .sold_out(sold_out), .restock_done(restock_done),
    .stock_out(stock_out)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 4; i++) ram[i] = 4'd9;
    mem_rdata = 4'd0;
  end

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      wcount <= wcount + 1;
    end
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  always @(negedge clk) begin
    total++;
    if (mem_we && mem_re) begin
      bad++;
      $display("FAIL we_re_overlap: we=%0b re=%0b required not both 1", mem_we, mem_re);
    end
    total++;
    if (!rst_n && (mem_we || mem_re)) begin
      bad++;
      $display("FAIL strobe_in_reset: we=%0b re=%0b required 0", mem_we, mem_re);
    end
    if (vend_ok) vcount++;
  end

  task automatic release_reset();
    vend_req = 0; restock_req = 0; sel = 0; restock_qty = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic r, input logic [1:0] s, input logic [3:0] q);
    @(negedge clk);
    vend_req = v; restock_req = r; sel = s; restock_qty = q;
    @(posedge clk);
    #1;
    vend_req = 0; restock_req = 0;
    sel = ~s; restock_qty = ~q;
  endtask

  task automatic test_reset();
    int w0;
    rst_n = 0;
    #12;
    total++;
    if (mem_we !== 1'b0 || mem_re !== 1'b0 || mem_addr !== 2'd0 || mem_wdata !== 4'd0) begin
      bad++;
      $display("FAIL reset_mem: we=%0b re=%0b addr=%0d wdata=%0d required 0 0 0 0", mem_we, mem_re, mem_addr, mem_wdata);
    end
    total++;
    if (busy !== 1'b1 || vend_ok !== 1'b0 || sold_out !== 1'b0 || restock_done !== 1'b0 || stock_out !== 4'd0) begin
      bad++;
      $display("FAIL reset_out: busy=%0b ok=%0b so=%0b rd=%0b stock=%0d required 1 0 0 0 0", busy, vend_ok, sold_out, restock_done, stock_out);
    end
    w0 = wcount;
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 2'd3 || mem_wdata !== 4'd5) begin
      bad++;
      $display("FAIL init_slot3: busy=%0b we=%0b addr=%0d wdata=%0d required 1 1 3 5", busy, mem_we, mem_addr, mem_wdata);
    end
    @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || (wcount - w0) != 4) begin
      bad++;
      $display("FAIL init_done: busy=%0b writes=%0d required 0 4", busy, wcount - w0);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (ram[i] !== 4'd5) begin
        bad++;
        $display("FAIL init_slot%0d: got %0d required 5", i, ram[i]);
      end
    end
  endtask

  task automatic test_vend_each();
    for (int s = 0; s < 4; s++) begin
      issue(1, 0, s[1:0], 4'd0);
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (vend_ok !== 1'b1 || stock_out !== 4'd4 || mem_we !== 1'b1 || mem_addr !== s[1:0] || mem_wdata !== 4'd4) begin
        bad++;
        $display("FAIL vend_slot%0d: ok=%0b stock=%0d we=%0b addr=%0d wd=%0d required 1 4 1 %0d 4", s, vend_ok, stock_out, mem_we, mem_addr, mem_wdata, s);
      end
      @(posedge clk);
      #1;
      total++;
      if (vend_ok !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL vend_end%0d: ok=%0b busy=%0b required 0 0", s, vend_ok, busy);
      end
    end
  endtask

  task automatic test_sold_out();
    int w0;
    release_reset();
    for (int n = 0; n < 5; n++) begin
      issue(1, 0, 2'd2, 4'd0);
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (vend_ok !== 1'b1 || sold_out !== 1'b0 || stock_out !== 4'(4 - n)) begin
        bad++;
        $display("FAIL vend_seq%0d: ok=%0b so=%0b stock=%0d required 1 0 %0d", n, vend_ok, sold_out, stock_out, 4 - n);
      end
      @(posedge clk);
      #1;
    end
    w0 = wcount;
    issue(1, 0, 2'd2, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (sold_out !== 1'b1 || vend_ok !== 1'b0 || stock_out !== 4'd0 || busy !== 1'b0 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL sold_out: so=%0b ok=%0b stock=%0d busy=%0b we=%0b required 1 0 0 0 0", sold_out, vend_ok, stock_out, busy, mem_we);
    end
    @(posedge clk);
    #1;
    total++;
    if (sold_out !== 1'b0 || wcount != w0 || ram[2] !== 4'd0) begin
      bad++;
      $display("FAIL sold_out_end: so=%0b writes=%0d ram2=%0d required 0 0 0", sold_out, wcount - w0, ram[2]);
    end
  endtask

  task automatic test_restock();
    release_reset();
    issue(0, 1, 2'd1, 4'd7);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (restock_done !== 1'b1 || vend_ok !== 1'b0 || stock_out !== 4'd12 || mem_we !== 1'b1 || mem_wdata !== 4'd12) begin
      bad++;
      $display("FAIL restock7: rd=%0b ok=%0b stock=%0d we=%0b wd=%0d required 1 0 12 1 12", restock_done, vend_ok, stock_out, mem_we, mem_wdata);
    end
    @(posedge clk);
    #1;
    issue(0, 1, 2'd1, 4'd9);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (restock_done !== 1'b1 || stock_out !== 4'd15) begin
      bad++;
      $display("FAIL restock_sat: rd=%0b stock=%0d required 1 15", restock_done, stock_out);
    end
    @(posedge clk);
    #1;
    total++;
    if (ram[1] !== 4'd15 || restock_done !== 1'b0) begin
      bad++;
      $display("FAIL restock_ram: ram1=%0d rd=%0b required 15 0", ram[1], restock_done);
    end
  endtask

  task automatic test_priority_busy();
    int v0;
    release_reset();
    v0 = vcount;
    issue(1, 1, 2'd3, 4'd2);
    @(posedge clk);
    #1;
    vend_req = 1; sel = 2'd0;
    @(posedge clk);
    #1;
    total++;
    if (vend_ok !== 1'b1 || restock_done !== 1'b0 || stock_out !== 4'd4) begin
      bad++;
      $display("FAIL both_req: ok=%0b rd=%0b stock=%0d required 1 0 4", vend_ok, restock_done, stock_out);
    end
    @(posedge clk);
    #1;
    vend_req = 0;
    repeat (6) @(posedge clk);
    #1;
    total++;
    if ((vcount - v0) != 1 || ram[0] !== 4'd5 || ram[3] !== 4'd4 || busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_ignore: pulses=%0d ram0=%0d ram3=%0d busy=%0b required 1 5 4 0", vcount - v0, ram[0], ram[3], busy);
    end
  endtask

  task automatic test_reset_abort();
    int w0;
    release_reset();
    issue(1, 0, 2'd0, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    total++;
    if (mem_we !== 1'b0 || vend_ok !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_now: we=%0b ok=%0b busy=%0b required 0 0 1", mem_we, vend_ok, busy);
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (ram[0] !== 4'd5) begin
      bad++;
      $display("FAIL abort_nowrite: ram0=%0d required 5", ram[0]);
    end
    w0 = wcount;
    @(negedge clk);
    rst_n = 1;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if ((wcount - w0) != 4 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_reinit: writes=%0d busy=%0b required 4 0", wcount - w0, busy);
    end
    issue(1, 0, 2'd0, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (vend_ok !== 1'b1 || stock_out !== 4'd4) begin
      bad++;
      $display("FAIL abort_vend: ok=%0b stock=%0d required 1 4", vend_ok, stock_out);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_vend_each();
    test_sold_out();
    test_restock();
    test_priority_busy();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
